// File: rtl/serial_paralelo_rx_pkg.sv
// Shared constants and types for the serial-to-parallel receiver.
// COMMA is the idle symbol the serializer emits when it has no valid data.
package serial_paralelo_rx_pkg;

  localparam logic [7:0] COMMA     = 8'hBC;
  localparam int unsigned BIT_CNT_W = 3;

  typedef logic [BIT_CNT_W-1:0] bit_cnt_t;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    LOCKING = 2'd1,
    LOCKED  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_paralelo_rx_if.sv
// Serial lane input and byte-level outputs of serial_paralelo_rx.
// comma_cnt exists only when SERIAL_PARALELO_RX_COMMA_CNT_EN is defined.
interface serial_paralelo_rx_if;

  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       strobe_out;
  logic       active;
`ifdef SERIAL_PARALELO_RX_COMMA_CNT_EN
  logic [7:0] comma_cnt;

  modport master (
    input  data_in,
    output data_out, valid_out, strobe_out, active, comma_cnt
  );

  modport slave (
    output data_in,
    input  data_out, valid_out, strobe_out, active, comma_cnt
  );
`else
  modport master (
    input  data_in,
    output data_out, valid_out, strobe_out, active
  );

  modport slave (
    output data_in,
    input  data_out, valid_out, strobe_out, active
  );
`endif

endinterface

// File: rtl/serial_paralelo_rx_comma_aligner.sv
// Shift register and byte-boundary generation: hunts for COMMA at any bit
// position while hunting, otherwise marks every 8th bit once aligned.
module serial_paralelo_rx_comma_aligner
  import serial_paralelo_rx_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       data_in,
  input  logic       hunting,
  output logic [7:0] word_next,
  output logic       is_comma,
  output logic       boundary
);

  logic [7:0] sr;
  bit_cnt_t   bit_cnt;

  assign word_next = {sr[6:0], data_in};
  assign is_comma  = (word_next == COMMA);
  assign boundary  = hunting ? is_comma : (bit_cnt == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else begin
      sr      <= word_next;
      bit_cnt <= boundary ? '0 : bit_cnt + bit_cnt_t'(1);
    end
  end

endmodule

// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel receiver: comma alignment, lock FSM and byte outputs.
// Define SERIAL_PARALELO_RX_COMMA_CNT_EN to add a saturating comma counter.
module serial_paralelo_rx
  import serial_paralelo_rx_pkg::*;
#(
  parameter logic [3:0] BC_LOCK = 4'd4
) (
  input  logic                 clk_32f,
  input  logic                 reset_L,
  serial_paralelo_rx_if.master bus
);

  state_t     state, state_next;
  logic [3:0] bc_cnt, bc_next;
  logic [7:0] data_q, data_next;
  logic       valid_q, valid_next;
  logic       strobe_q, strobe_next;
  logic       active_q, active_next;

  logic [7:0] word_next;
  logic       is_comma;
  logic       boundary;
  logic       hunting;

  assign hunting = (state == HUNT);

  serial_paralelo_rx_comma_aligner u_aligner (
    .clk       (clk_32f),
    .rst_n     (reset_L),
    .data_in   (bus.data_in),
    .hunting   (hunting),
    .word_next (word_next),
    .is_comma  (is_comma),
    .boundary  (boundary)
  );

`ifdef SERIAL_PARALELO_RX_COMMA_CNT_EN
  logic [7:0] cnt_q, cnt_next;
`endif

  always_comb begin
    state_next  = state;
    bc_next     = bc_cnt;
    data_next   = data_q;
    valid_next  = valid_q;
    strobe_next = 1'b0;
`ifdef SERIAL_PARALELO_RX_COMMA_CNT_EN
    cnt_next    = cnt_q;
`endif
    case (state)
      HUNT: begin
        if (boundary) begin
          bc_next    = 4'd1;
          state_next = (BC_LOCK == 4'd1) ? LOCKED : LOCKING;
        end
      end
      LOCKING: begin
        if (boundary) begin
          if (is_comma) begin
            bc_next = bc_cnt + 4'd1;
            if (bc_cnt + 4'd1 == BC_LOCK)
              state_next = LOCKED;
          end else begin
            bc_next    = '0;
            state_next = HUNT;
          end
        end
      end
      LOCKED: begin
        if (boundary) begin
          data_next   = word_next;
          valid_next  = !is_comma;
          strobe_next = 1'b1;
`ifdef SERIAL_PARALELO_RX_COMMA_CNT_EN
          if (is_comma && cnt_q != '1)
            cnt_next = cnt_q + 8'd1;
`endif
        end
      end
      default: begin
        bc_next    = '0;
        state_next = HUNT;
      end
    endcase
    active_next = (state_next == LOCKED);
  end

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state    <= HUNT;
      bc_cnt   <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state    <= state_next;
      bc_cnt   <= bc_next;
      data_q   <= data_next;
      valid_q  <= valid_next;
      strobe_q <= strobe_next;
      active_q <= active_next;
    end
  end

`ifdef SERIAL_PARALELO_RX_COMMA_CNT_EN
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) cnt_q <= '0;
    else          cnt_q <= cnt_next;
  end

  assign bus.comma_cnt = cnt_q;
`endif

  assign bus.data_out   = data_q;
  assign bus.valid_out  = valid_q;
  assign bus.strobe_out = strobe_q;
  assign bus.active     = active_q;

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Scoreboard bench for serial_paralelo_rx: the driver queues expected bytes,
// the monitor checks each strobe's data, valid flag and 8-cycle spacing.
module tb_serial_paralelo_rx;
  import serial_paralelo_rx_pkg::*;

  logic clk_32f = 1'b0;
  logic reset_L = 1'b0;

  serial_paralelo_rx_if rx_if ();

  serial_paralelo_rx #(.BC_LOCK(4'd4)) dut (
    .clk_32f (clk_32f),
    .reset_L (reset_L),
    .bus     (rx_if.master)
  );

  always #5 clk_32f = ~clk_32f;

  int tests = 0;
  int fails = 0;
  logic [8:0] exp_q[$];
  int cyc = 0;
  int last_strobe = -1;
  logic prev_active = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: lock edge counts as the reference for the first strobe
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk_32f);
      cyc++;
      if (!rx_if.active) last_strobe = -1;
      else if (!prev_active) last_strobe = cyc;
      prev_active = rx_if.active;
      if (rx_if.strobe_out) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_strobe: got data %0h valid %0b, nothing expected", rx_if.data_out, rx_if.valid_out);
        end else begin
          e = exp_q.pop_front();
          chk("data_out", rx_if.data_out, e[8:1]);
          chk("valid_out", rx_if.valid_out, e[0]);
        end
        if (last_strobe >= 0) chk("strobe_period", cyc - last_strobe, 8);
        last_strobe = cyc;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_bit(input logic b);
    rx_if.data_in = b;
    @(negedge clk_32f);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit emit);
    if (emit) exp_q.push_back({b, (b != COMMA)});
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic lock_run(input string name);
    for (int i = 0; i < 4; i++) begin
      send_byte(COMMA, 1'b0);
      chk(name, rx_if.active, (i == 3) ? 1 : 0);
    end
  endtask

  task automatic do_reset();
    #2 reset_L = 1'b0;
    rx_if.data_in = 1'b0;
    repeat (2) @(negedge clk_32f);
    reset_L = 1'b1;
  endtask

  initial begin
    int offset;
    rx_if.data_in = 1'b0;
    repeat (2) @(negedge clk_32f);
    chk("reset_data_out", rx_if.data_out, 8'h00);
    chk("reset_valid_out", rx_if.valid_out, 0);
    chk("reset_strobe_out", rx_if.strobe_out, 0);
    chk("reset_active", rx_if.active, 0);
    reset_L = 1'b1;

    // Lock from a random bit offset, then idle commas
    offset = $urandom_range(0, 7);
    repeat (offset) send_bit(1'($urandom_range(0, 1)));
    lock_run("active_first_lock");
    send_byte(COMMA, 1'b1);
    send_byte(COMMA, 1'b1);

    send_byte(8'hA5, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_byte(8'hBC, 1'b1);

    // Interrupted comma run must fall back to hunting
    do_reset();
    for (int i = 0; i < 3; i++) send_byte(COMMA, 1'b0);
    send_byte(8'h00, 1'b0);
    chk("active_after_broken_run", rx_if.active, 0);
    lock_run("active_second_run");

    // Unaligned BC across 5E/F0 must not realign
    send_byte(8'h5E, 1'b1);
    send_byte(8'hF0, 1'b1);

    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    chk("pre_reset_data_out", rx_if.data_out, 8'hF0);
    #2 reset_L = 1'b0;
    #1;
    chk("async_rst_data_out", rx_if.data_out, 8'h00);
    chk("async_rst_valid_out", rx_if.valid_out, 0);
    chk("async_rst_strobe_out", rx_if.strobe_out, 0);
    chk("async_rst_active", rx_if.active, 0);
    rx_if.data_in = 1'b0;
    repeat (2) @(negedge clk_32f);
    reset_L = 1'b1;
    lock_run("active_relock");
    send_byte(8'h81, 1'b1);
    send_byte(8'h00, 1'b1);

`ifdef SERIAL_PARALELO_RX_COMMA_CNT_EN
    chk("comma_cnt_after_relock", rx_if.comma_cnt, 8'h00);
    repeat (300) send_byte(COMMA, 1'b1);
    chk("comma_cnt_saturated", rx_if.comma_cnt, 8'hFF);
`endif

    repeat (3) @(negedge clk_32f);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_paralelo_rx.md
Name: serial_paralelo_rx

Overview:
Serial-to-parallel receiver stage, directly downstream of the transmit serializer on the serial lane. Consumes the MSB-first 1-bit stream on clk_32f, finds byte alignment by hunting for the idle comma 8'hBC, and declares lock after a run of aligned commas. Once locked, it presents each received byte with a valid flag (comma = idle = not valid) and a one-cycle strobe per byte. Feeds the byte-level receive logic.

Parameters:
COMMA, 8'hBC, idle/alignment symbol sent by the serializer when its valid_in is low
BC_LOCK, 4, consecutive aligned commas needed to declare lock (range 1..15)

Ports:
clk_32f  input  1  bit-rate clock, one serial bit per rising edge
reset_L  input  1  reset, asynchronous, active-low
data_in  input  1  serial bit, MSB of each byte first
data_out  output  8  last received byte, held until the next byte boundary
valid_out  output  1  1 when locked and data_out != COMMA; held with data_out
strobe_out  output  1  one-cycle pulse on the edge that updates data_out
active  output  1  1 while in LOCKED

Behaviour:
- Clocking and reset: one clock (clk_32f); reset_L is asynchronous and active-low.
- Reset values: data_out = 0, valid_out = 0, strobe_out = 0, active = 0, shift reg = 0, bit_cnt = 0, bc_cnt = 0, state = HUNT. Reset asserted mid-byte aborts immediately; after release, hunting starts from scratch.
- Shift register sr[7:0] shifts every edge: sr <= {sr[6:0], data_in}. Comb word_next = {sr[6:0], data_in}.
- Boundary edge: in HUNT, any edge where word_next == COMMA. In LOCKING or LOCKED, the edge where bit_cnt == 7. On a boundary edge bit_cnt <= 0; otherwise bit_cnt <= bit_cnt + 1 (wraps 7->0).
- FSM:
  - HUNT: on a boundary edge, bc_cnt <= 1 and go to LOCKING (go directly to LOCKED if BC_LOCK == 1).
  - LOCKING: on a boundary edge, if word_next == COMMA then bc_cnt++; on reaching BC_LOCK go to LOCKED. A non-comma word clears bc_cnt and returns to HUNT. No outputs are produced in this state.
  - LOCKED: stays locked until reset. On each boundary edge: data_out <= word_next, valid_out <= (word_next != COMMA), strobe_out <= 1. On all other edges strobe_out <= 0.
- active is registered: active = 1 from the edge entering LOCKED onward.
- Latency: the last bit of a byte is sampled at edge k. data_out, valid_out and strobe_out reflect that byte right after edge k, so latency is 0 cycles after the final bit.
- The first strobe is issued one full byte (8 edges) after the edge that entered LOCKED; the locking comma itself is not emitted.
- Commas that appear unaligned inside data in LOCKED are ignored (no realignment).
- Width rules: bit_cnt is 3 bits with natural wrap; bc_cnt is 4 bits and never exceeds BC_LOCK.

Optional Feature:
SERIAL_PARALELO_RX_COMMA_CNT_EN
- Defined: adds output port comma_cnt[7:0], reset 0. It increments on each LOCKED boundary edge where word_next == COMMA and saturates at 8'hFF.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package holds: COMMA default 8'hBC (shared with the serializer), state encodings HUNT = 2'd0, LOCKING = 2'd1, LOCKED = 2'd2, and the bit_cnt width constant 3.
- Natural sub-module: comma_aligner (shift register, word_next, bit_cnt, boundary generation).
- The FSM and output registers stay in the top module.

Test Plan:
- Reset then 6 bytes of continuous 8'hBC starting at a random bit offset -> active rises on the edge completing the 4th aligned comma; valid_out stays 0; strobes then every 8 clocks with data_out = 8'hBC.
- Lock, then bytes 8'hA5, 8'h3C, 8'hBC -> strobes 8 cycles apart with data_out/valid_out = A5/1, 3C/1, BC/0.
- 3 commas then 8'h00 then 4 commas -> no lock after the first run (returns to HUNT); active rises after the second run of 4.
- Locked, data byte 8'h5E followed by 8'hF0 (contains an unaligned BC pattern across the boundary) -> no realignment; data_out = 5E then F0, strobe period stays 8.
- reset_L pulled low mid-byte while locked -> outputs go to 0 asynchronously without a clock; after release the block relocks only after 4 new commas.
- With SERIAL_PARALELO_RX_COMMA_CNT_EN: 300 commas after lock -> comma_cnt saturates at 8'hFF and holds.
